// File: rtl/xdma_pkg.sv
// Shared types for the XDMA write path: FSM states, beat counter width and the default AXI4+ATOP bus types.
package xdma_pkg;

    localparam int unsigned BeatCntWidth = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } xdma_state_e;

    localparam int unsigned AxiAddrWidth = 32;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiUserWidth = 1;

    localparam logic [1:0] AxiBurstIncr = 2'b01;

    typedef logic [AxiAddrWidth-1:0]   xdma_addr_t;
    typedef logic [AxiDataWidth-1:0]   xdma_data_t;
    typedef logic [AxiDataWidth/8-1:0] xdma_strb_t;
    typedef logic [AxiIdWidth-1:0]     xdma_id_t;
    typedef logic [AxiUserWidth-1:0]   xdma_user_t;

    typedef struct packed {
        xdma_id_t   id;
        xdma_addr_t addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        xdma_user_t user;
    } xdma_aw_chan_t;

    typedef struct packed {
        xdma_data_t data;
        xdma_strb_t strb;
        logic       last;
        xdma_user_t user;
    } xdma_w_chan_t;

    typedef struct packed {
        xdma_id_t   id;
        logic [1:0] resp;
        xdma_user_t user;
    } xdma_b_chan_t;

    typedef struct packed {
        xdma_id_t   id;
        xdma_addr_t addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        xdma_user_t user;
    } xdma_ar_chan_t;

    typedef struct packed {
        xdma_id_t   id;
        xdma_data_t data;
        logic [1:0] resp;
        logic       last;
        xdma_user_t user;
    } xdma_r_chan_t;

    typedef struct packed {
        xdma_aw_chan_t aw;
        logic          aw_valid;
        xdma_w_chan_t  w;
        logic          w_valid;
        logic          b_ready;
        xdma_ar_chan_t ar;
        logic          ar_valid;
        logic          r_ready;
    } xdma_axi_req_t;

    typedef struct packed {
        logic          aw_ready;
        logic          ar_ready;
        logic          w_ready;
        logic          b_valid;
        xdma_b_chan_t  b;
        logic          r_valid;
        xdma_r_chan_t  r;
    } xdma_axi_rsp_t;

endpackage

// File: rtl/xdma_write_to_axi.sv
// Turns one burst command plus a stream of data beats into a single AXI4 INCR write burst.
// Latency: AW one cycle after command accept; W is a combinational pass-through; done/error pulse on B handshake.
// Backpressure: cmd_ready only in IDLE; data_ready follows w_ready in W and is low elsewhere.
module xdma_write_to_axi
    import xdma_pkg::*;
#(
    parameter type     axi_out_req_t  = xdma_axi_req_t,
    parameter type     axi_out_resp_t = xdma_axi_rsp_t,
    parameter type     data_t         = xdma_data_t,
    parameter type     addr_t         = xdma_addr_t,
    parameter type     strb_t         = xdma_strb_t,
    parameter type     axi_id_t       = xdma_id_t,
    parameter axi_id_t AxiId          = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  addr_t         cmd_addr_i,
    input  logic [7:0]    cmd_len_i,
    input  logic [2:0]    cmd_size_i,
    input  logic          data_valid_i,
    output logic          data_ready_o,
    input  data_t         data_i,
    input  strb_t         strb_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output axi_out_req_t  axi_req_o,
    input  axi_out_resp_t axi_rsp_i
);

    xdma_state_e             r_state;
    xdma_state_e             w_state_d;
    addr_t                   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [BeatCntWidth-1:0] r_cnt;

    logic w_last;
    logic w_w_hs;
    logic w_unused;

    assign w_last = (r_cnt == '0);
    assign w_w_hs = (r_state == W) && data_valid_i && axi_rsp_i.w_ready;
    assign busy_o = (r_state != IDLE);

    // Read channel, B id/user and the low response bit have no role in a write-only engine.
    assign w_unused = ^{axi_rsp_i.ar_ready, axi_rsp_i.r_valid, axi_rsp_i.r,
                        axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == IDLE) && cmd_valid_i) begin
                r_addr <= cmd_addr_i;
                r_len  <= cmd_len_i;
                r_size <= cmd_size_i;
                r_cnt  <= cmd_len_i;
            end
            // Hold at zero on the last beat so a 256-beat burst never wraps.
            if (w_w_hs && !w_last) begin
                r_cnt <= r_cnt - BeatCntWidth'(1);
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        axi_req_o    = '0;
        cmd_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_state_d = AW;
                end
            end
            AW: begin
                axi_req_o.aw_valid  = 1'b1;
                axi_req_o.aw.id     = AxiId;
                axi_req_o.aw.addr   = r_addr;
                axi_req_o.aw.len    = r_len;
                axi_req_o.aw.size   = r_size;
                axi_req_o.aw.burst  = AxiBurstIncr;
                if (axi_rsp_i.aw_ready) begin
                    w_state_d = W;
                end
            end
            W: begin
                axi_req_o.w_valid   = data_valid_i;
                axi_req_o.w.data    = data_i;
                axi_req_o.w.strb    = strb_i;
                axi_req_o.w.last    = w_last;
                data_ready_o        = axi_rsp_i.w_ready;
                if (w_w_hs && w_last) begin
                    w_state_d = B;
                end
            end
            B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    done_o    = 1'b1;
                    error_o   = axi_rsp_i.b.resp[1];
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xdma_write_to_axi.sv
// Directed bench for xdma_write_to_axi: small AXI slave/data source, beat log and hand-computed expectations.
module tb_xdma_write_to_axi;

    localparam logic [3:0] TbAxiId = 4'h5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic [2:0]  cmd_size_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [63:0] data_i = '0;
    logic [7:0]  strb_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    xdma_pkg::xdma_axi_req_t axi_req;
    xdma_pkg::xdma_axi_rsp_t axi_rsp;

    logic       tb_aw_ready = 1'b0;
    logic       tb_w_ready  = 1'b0;
    logic       tb_b_valid  = 1'b0;
    logic [1:0] tb_b_resp   = 2'b00;
    bit         src_rand = 1'b0;
    bit         slv_rand = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        axi_rsp          = '0;
        axi_rsp.aw_ready = tb_aw_ready;
        axi_rsp.w_ready  = tb_w_ready;
        axi_rsp.b_valid  = tb_b_valid;
        axi_rsp.b.resp   = tb_b_resp;
        axi_rsp.b.id     = 4'hA;
    end

    xdma_write_to_axi #(
        .AxiId(TbAxiId)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_size_i  (cmd_size_i),
        .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .data_i      (data_i),
        .strb_i      (strb_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .axi_req_o   (axi_req),
        .axi_rsp_i   (axi_rsp)
    );

    function automatic logic [63:0] pat_data(input int k);
        return {32'hCAFE_0000 + 32'(k), 32'h1357_9BDF ^ 32'(k * 7)};
    endfunction

    function automatic logic [7:0] pat_strb(input int k);
        return 8'(k * 37 + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data source and W-side slave: beat index restarts on each accepted command.
    int src_idx = 0;
    bit src_hs;
    bit cmd_hs;
    always begin
        @(negedge clk_i);
        src_hs = data_valid_i && data_ready_o;
        cmd_hs = cmd_valid_i && cmd_ready_o;
        @(posedge clk_i);
        #1;
        if (!rst_ni || cmd_hs) src_idx = 0;
        else if (src_hs)       src_idx++;
        data_i = pat_data(src_idx);
        strb_i = pat_strb(src_idx);
        if (!(data_valid_i && !src_hs)) data_valid_i = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        tb_w_ready = slv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Bus log, sampled mid-cycle.
    logic [63:0] wq_data[$];
    logic [7:0]  wq_strb[$];
    logic        wq_last[$];
    int aw_hs_cnt = 0;
    int done_cnt  = 0;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (axi_req.aw_valid && axi_rsp.aw_ready) aw_hs_cnt++;
            if (axi_req.w_valid && axi_rsp.w_ready) begin
                wq_data.push_back(axi_req.w.data);
                wq_strb.push_back(axi_req.w.strb);
                wq_last.push_back(axi_req.w.last);
            end
            if (done_o) done_cnt++;
        end
    end

    int beat_base = 0;
    int aw_base   = 0;
    int done_base = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mark_log();
        beat_base = wq_data.size();
        aw_base   = aw_hs_cnt;
        done_base = done_cnt;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input bit hold);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_size_i  = size;
        @(negedge clk_i);
        chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        chk("aw_valid_lat0", 64'(axi_req.aw_valid), 64'd0);
        tick();
        if (!hold) begin
            cmd_valid_i = 1'b0;
            cmd_addr_i  = '0;
            cmd_len_i   = '0;
            cmd_size_i  = '0;
        end
        @(negedge clk_i);
        chk("aw_valid_lat1", 64'(axi_req.aw_valid), 64'd1);
        chk("aw_addr", 64'(axi_req.aw.addr), 64'(addr));
        chk("aw_len", 64'(axi_req.aw.len), 64'(len));
        chk("aw_size", 64'(axi_req.aw.size), 64'(size));
        chk("aw_burst", 64'(axi_req.aw.burst), 64'd1);
        chk("aw_id", 64'(axi_req.aw.id), 64'(TbAxiId));
        chk("aw_atop", 64'(axi_req.aw.atop), 64'd0);
        chk("busy_aw", 64'(busy_o), 64'd1);
        chk("cmd_ready_aw", 64'(cmd_ready_o), 64'd0);
        chk("data_ready_aw", 64'(data_ready_o), 64'd0);
    endtask

    task automatic wait_b_ready(input int budget);
        int n = 0;
        @(negedge clk_i);
        while (!axi_req.b_ready && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("b_ready_seen", 64'(axi_req.b_ready), 64'd1);
    endtask

    task automatic finish_b(input logic [1:0] resp, input logic exp_err);
        tick();
        tb_b_valid = 1'b1;
        tb_b_resp  = resp;
        @(negedge clk_i);
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("error_pulse", 64'(error_o), 64'(exp_err));
        tick();
        tb_b_valid = 1'b0;
        tb_b_resp  = 2'b00;
        @(negedge clk_i);
        chk("done_low_after", 64'(done_o), 64'd0);
        chk("error_low_after", 64'(error_o), 64'd0);
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready_o), 64'd1);
    endtask

    task automatic check_beats(input int n);
        int got_n;
        got_n = wq_data.size() - beat_base;
        chk("w_beat_count", 64'(got_n), 64'(n));
        for (int i = 0; i < n && i < got_n; i++) begin
            chk("w_data", wq_data[beat_base + i], pat_data(i));
            chk("w_strb", 64'(wq_strb[beat_base + i]), 64'(pat_strb(i)));
            chk("w_last", 64'(wq_last[beat_base + i]), 64'(i == n - 1));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_aw_valid", 64'(axi_req.aw_valid), 64'd0);
        chk("rst_w_valid", 64'(axi_req.w_valid), 64'd0);
        chk("rst_b_ready", 64'(axi_req.b_ready), 64'd0);
        chk("rst_data_ready", 64'(data_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_ar_valid", 64'(axi_req.ar_valid), 64'd0);
        chk("rst_r_ready", 64'(axi_req.r_ready), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk_i);
        check_reset_outputs();
        tick();
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("cmd_ready_after_rst", 64'(cmd_ready_o), 64'd1);
        chk("busy_after_rst", 64'(busy_o), 64'd0);

        // Basic 4-beat burst, no stalls
        tick();
        mark_log();
        tb_aw_ready = 1'b1;
        send_cmd(32'h0000_1000, 8'd3, 3'd3, 1'b0);
        wait_b_ready(50);
        finish_b(2'b00, 1'b0);
        check_beats(4);
        chk("t1_aw_count", 64'(aw_hs_cnt - aw_base), 64'd1);
        chk("t1_done_count", 64'(done_cnt - done_base), 64'd1);

        // Single beat, SLVERR response
        tick();
        mark_log();
        send_cmd(32'h0000_1100, 8'd0, 3'd3, 1'b0);
        wait_b_ready(50);
        finish_b(2'b10, 1'b1);
        check_beats(1);

        // AW stalled for 5 cycles
        tick();
        mark_log();
        tb_aw_ready = 1'b0;
        send_cmd(32'h0000_2040, 8'd1, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("aw_stall_valid", 64'(axi_req.aw_valid), 64'd1);
            chk("aw_stall_addr", 64'(axi_req.aw.addr), 64'h2040);
            chk("aw_stall_len", 64'(axi_req.aw.len), 64'd1);
            chk("aw_stall_w_valid", 64'(axi_req.w_valid), 64'd0);
            chk("aw_stall_data_ready", 64'(data_ready_o), 64'd0);
        end
        chk("aw_stall_no_beats", 64'(wq_data.size() - beat_base), 64'd0);
        tick();
        tb_aw_ready = 1'b1;
        wait_b_ready(50);
        finish_b(2'b00, 1'b0);
        check_beats(2);

        // 256 beats with random stalls on both sides
        tick();
        mark_log();
        src_rand = 1'b1;
        slv_rand = 1'b1;
        send_cmd(32'h0000_4000, 8'd255, 3'd3, 1'b0);
        wait_b_ready(4000);
        src_rand = 1'b0;
        slv_rand = 1'b0;
        finish_b(2'b00, 1'b0);
        check_beats(256);

        // Reset during beat 2 of an 8-beat burst
        tick();
        mark_log();
        send_cmd(32'h0000_5000, 8'd7, 3'd3, 1'b0);
        begin
            int n = 0;
            @(negedge clk_i);
            #2;
            while ((wq_data.size() - beat_base) < 2 && n < 50) begin
                @(negedge clk_i);
                #2;
                n++;
            end
            chk("rst_beat2_reached", 64'(wq_data.size() - beat_base), 64'd2);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_reset_outputs();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        mark_log();
        send_cmd(32'h0000_6000, 8'd1, 3'd3, 1'b0);
        wait_b_ready(50);
        finish_b(2'b00, 1'b0);
        check_beats(2);

        // Command held high across a burst: back-to-back bursts
        tick();
        mark_log();
        send_cmd(32'h0000_3000, 8'd1, 3'd3, 1'b1);
        @(negedge clk_i);
        chk("hold_cmd_ready_w", 64'(cmd_ready_o), 64'd0);
        wait_b_ready(50);
        chk("hold_cmd_ready_b", 64'(cmd_ready_o), 64'd0);
        tick();
        tb_b_valid = 1'b1;
        @(negedge clk_i);
        chk("hold_done", 64'(done_o), 64'd1);
        chk("hold_cmd_ready_done", 64'(cmd_ready_o), 64'd0);
        tick();
        tb_b_valid = 1'b0;
        @(negedge clk_i);
        chk("hold_idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("hold_idle_aw_valid", 64'(axi_req.aw_valid), 64'd0);
        tick();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("hold_second_aw", 64'(axi_req.aw_valid), 64'd1);
        chk("hold_second_addr", 64'(axi_req.aw.addr), 64'h3000);
        wait_b_ready(50);
        finish_b(2'b00, 1'b0);
        chk("hold_aw_count", 64'(aw_hs_cnt - aw_base), 64'd2);
        chk("hold_done_count", 64'(done_cnt - done_base), 64'd2);
        chk("hold_beat_count", 64'(wq_data.size() - beat_base), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
